asi_w: RTL and testbench
========================

Name: asi_w

Overview:
- AXI slave write interface: the responder end of the AXI write protocol, presenting a per-beat user write port.
- Single clock domain (ACLK).
- Accepts AW and W from an AXI master, generates per-beat addresses for FIXED/INCR/WRAP bursts, and forwards beats to a user memory/register port.
- Returns one B response per burst; the response is buffered in a B FIFO.

Parameters:
- AXI_DW, 128, data bus width
- AXI_AW, 32, address width (≤32)
- AXI_IW, 8, ID width
- AXI_LW, 8, AWLEN width
- AXI_SW, 3, AWSIZE width
- AXI_BURSTW, 2, AWBURST width
- AXI_BRESPW, 2, BRESP width
- ASI_AD, 4, AW buffer depth (power of 2)
- ASI_BD, 4, B buffer depth (power of 2)
- AXI_BYTES, AXI_DW/8, bytes per beat (derived)
- AXI_WSTRBW, AXI_BYTES, WSTRB width (derived)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  IW/AW/LW/SW/BURSTW  AXI AW payload
- AWVALID  in  1; AWREADY  out  1
- WDATA  in  DW; WSTRB  in  WSTRBW; WLAST  in  1
- WVALID  in  1; WREADY  out  1
- BID  out  IW; BRESP  out  BRESPW; BVALID  out  1; BREADY  in  1
- usr_wid  out  IW  ID of the current burst
- usr_waddr  out  AW  byte address of the current beat
- usr_wdata  out  DW; usr_wstrb  out  WSTRBW
- usr_wlast  out  1  beat count == AWLEN
- usr_wvalid  out  1; usr_wready  in  1
- usr_werr  in  1  user error, sampled on the usr handshake

Behaviour:
- Reset values: AWREADY=1 once ARESETn is high (0 while asserted); WREADY=0; BVALID=0; BID=0; BRESP=0; usr_wvalid=0; usr_waddr=0; usr_wid=0; usr_wlast=0.
- Reset mid-burst: everything is cleared; in-flight beats and B entries are discarded; no B is issued.
- AW FIFO:
  - Depth ASI_AD; AWREADY = !aff_full.
  - Push on AWVALID&AWREADY; pop when a burst starts.
- FSM states IDLE and BURST.
- IDLE→BURST when the AW FIFO is non-empty and a B slot is free (bff_cnt < ASI_BD):
  - pop AW;
  - load addr, id, len, size, burst;
  - beat_cc=0; err=0.
- BURST:
  - Beat handshake (hs) = WVALID & usr_wready.
  - usr_wvalid = WVALID; WREADY = usr_wready. Zero-latency combinational pass-through; both are gated to 0 in IDLE.
  - usr_wdata/usr_wstrb = WDATA/WSTRB; usr_wlast = (beat_cc==len).
- On hs at the last beat (beat_cc==len):
  - push {id, resp} into the B FIFO;
  - if the start condition holds that same cycle, go back-to-back to the next burst, using bff_cnt+1 < ASI_BD; otherwise go to IDLE.
- On hs at any other beat: beat_cc+1, advance addr.
- The burst always ends on the AWLEN count, never on WLAST.
- Address update, with bytes = 1<<size:
  - FIXED: addr unchanged.
  - INCR, and reserved 2'b11: addr+bytes, no 4KB check.
  - WRAP: wsz=(len+1)*bytes; addr = (addr & ~(wsz-1)) | ((addr+bytes) & (wsz-1)).
- Error accumulation: err is set on any hs where
  - WLAST != usr_wlast, or
  - usr_werr=1,
  - or at start when burst==2'b11, size > log2(AXI_BYTES), or WRAP with len ∉ {1,3,7,15}.
- resp = err ? SLVERR(2'b10) : OKAY(2'b00).
- B FIFO:
  - Depth ASI_BD; BVALID = !bff_empty; BID/BRESP = head entry; pop on BVALID&BREADY.
  - If push and pop occur in the same cycle, the count is unchanged.
- Reservation rule: a burst starts only when its B entry is guaranteed space, so the B FIFO never overflows. BREADY low indefinitely stalls new bursts (WREADY=0) after ASI_BD pending responses.
- Single active burst; write interleaving is not supported. W beats arriving before AW are held off with WREADY=0.

Decomposition:
- Package asi_pkg:
  - burst enum FIXED/INCR/WRAP/RSVD;
  - resp constants OKAY/EXOKAY/SLVERR/DECERR;
  - FSM state enum.
- Sub-module sfifo (parameters AW, DW): synchronous FIFO with full, empty and count outputs.
  - Instantiated twice: AW buffer and B buffer.
  - Shared with a future asi_r.

Test Plan:
- INCR, AWID=5, AWADDR=0x1000, AWLEN=3, AWSIZE=4 → usr_waddr 0x1000, 0x1010, 0x1020, 0x1030; usr_wlast on beat 3 only; then BID=5, BRESP=OKAY.
- WRAP, AWADDR=0x1018, AWLEN=3, AWSIZE=4 → usr_waddr 0x1018, 0x1028, 0x1038, 0x1008; BRESP=OKAY.
- FIXED, AWADDR=0x40, AWLEN=1 → 0x40 on both beats; WLAST asserted on beat 0 → BRESP=SLVERR, and the burst still takes 2 beats.
- BREADY=0, 5 back-to-back INCR AWLEN=0 bursts → exactly 4 B entries; WREADY stays 0 for the 5th until one B pops, then it completes.
- usr_werr=1 on beat 2 of an AWLEN=7 burst, with random usr_wready stalls → all 8 beats delivered in order; BRESP=SLVERR.
- ARESETn pulsed low at beat 1 of AWLEN=3 → BVALID=0 and the AW FIFO empty afterwards; a fresh burst completes with OKAY.

Source files
------------

// File: rtl/asi_pkg.sv
// Shared types for the AXI slave write/read interfaces.
package asi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } st_e;

endpackage

// File: rtl/sfifo.sv
// Synchronous FIFO, depth 2**AW; pushes when full and pops when empty are ignored.
module sfifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   cnt_o
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/asi_w.sv
// AXI slave write interface: buffers AW, walks burst addresses, forwards beats to a
// user port and queues one B response per burst.
module asi_w import asi_pkg::*; #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2,
  parameter int AXI_BRESPW = 2,
  parameter int ASI_AD     = 4,
  parameter int ASI_BD     = 4,
  parameter int AXI_BYTES  = AXI_DW/8,
  parameter int AXI_WSTRBW = AXI_BYTES
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [AXI_IW-1:0]     AWID,
  input  logic [AXI_AW-1:0]     AWADDR,
  input  logic [AXI_LW-1:0]     AWLEN,
  input  logic [AXI_SW-1:0]     AWSIZE,
  input  logic [AXI_BURSTW-1:0] AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [AXI_DW-1:0]     WDATA,
  input  logic [AXI_WSTRBW-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [AXI_IW-1:0]     BID,
  output logic [AXI_BRESPW-1:0] BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [AXI_IW-1:0]     usr_wid,
  output logic [AXI_AW-1:0]     usr_waddr,
  output logic [AXI_DW-1:0]     usr_wdata,
  output logic [AXI_WSTRBW-1:0] usr_wstrb,
  output logic                  usr_wlast,
  output logic                  usr_wvalid,
  input  logic                  usr_wready,
  input  logic                  usr_werr
);
  localparam int AFW   = AXI_IW + AXI_AW + AXI_LW + AXI_SW + AXI_BURSTW;
  localparam int BFW   = AXI_IW + AXI_BRESPW;
  localparam int AAW   = $clog2(ASI_AD);
  localparam int BAW   = $clog2(ASI_BD);
  localparam int SZMAX = $clog2(AXI_BYTES);

  st_e                   state_q;
  logic [AXI_AW-1:0]     addr_q, addr_nxt, bytes, wsz;
  logic [AXI_IW-1:0]     id_q;
  logic [AXI_LW-1:0]     len_q, beat_q;
  logic [AXI_SW-1:0]     size_q;
  logic [AXI_BURSTW-1:0] burst_q;
  logic                  err_q;

  logic [AFW-1:0]        aff_din, aff_dout;
  logic                  aff_full, aff_empty, aff_pop;
  logic [AAW:0]          aff_cnt;
  logic [BFW-1:0]        bff_din, bff_dout;
  logic                  bff_full, bff_empty, bff_push, bff_pop;
  logic [BAW:0]          bff_cnt;

  logic [AXI_IW-1:0]     a_id, bh_id;
  logic [AXI_AW-1:0]     a_addr;
  logic [AXI_LW-1:0]     a_len;
  logic [AXI_SW-1:0]     a_size;
  logic [AXI_BURSTW-1:0] a_burst;
  logic [AXI_BRESPW-1:0] bh_resp;

  logic busy, hs, last, last_hs, err_fin, bslot, start, start_err;
  int   b_used;

  assign aff_din = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
  assign {a_id, a_addr, a_len, a_size, a_burst} = aff_dout;

  sfifo #(.AW(AAW), .DW(AFW)) u_aff (
    .clk_i(ACLK), .rst_ni(ARESETn),
    .push_i(AWVALID & AWREADY), .din_i(aff_din), .pop_i(aff_pop),
    .dout_o(aff_dout), .full_o(aff_full), .empty_o(aff_empty), .cnt_o(aff_cnt)
  );

  sfifo #(.AW(BAW), .DW(BFW)) u_bff (
    .clk_i(ACLK), .rst_ni(ARESETn),
    .push_i(bff_push), .din_i(bff_din), .pop_i(bff_pop),
    .dout_o(bff_dout), .full_o(bff_full), .empty_o(bff_empty), .cnt_o(bff_cnt)
  );

  assign AWREADY    = ARESETn & ~aff_full;
  assign busy       = (state_q == BURST);
  assign usr_wvalid = busy & WVALID;
  assign WREADY     = busy & usr_wready;
  assign usr_wdata  = WDATA;
  assign usr_wstrb  = WSTRB;
  assign last       = busy & (beat_q == len_q);
  assign usr_wlast  = last;
  assign usr_waddr  = addr_q;
  assign usr_wid    = id_q;

  assign hs      = busy & WVALID & usr_wready;
  assign last_hs = hs & last;
  assign err_fin = err_q | (WLAST != last) | usr_werr;

  // The burst finishing this cycle already owns one B slot, so count it as used.
  assign b_used = 32'(bff_cnt) + 32'(last_hs);
  assign bslot  = (b_used < ASI_BD);
  assign start  = (~busy | last_hs) & (aff_cnt != '0) & bslot;
  assign aff_pop = start & ~aff_empty;

  assign start_err = (a_burst == RSVD) || (32'(a_size) > SZMAX) ||
                     ((a_burst == WRAP) && !(a_len inside {1, 3, 7, 15}));

  always_comb begin
    bytes = AXI_AW'(1) << size_q;
    wsz   = (AXI_AW'(len_q) + AXI_AW'(1)) * bytes;
    case (burst_q)
      FIXED:   addr_nxt = addr_q;
      WRAP:    addr_nxt = (addr_q & ~(wsz - 1'b1)) | ((addr_q + bytes) & (wsz - 1'b1));
      default: addr_nxt = addr_q + bytes;
    endcase
  end

  assign bff_push = last_hs & ~bff_full;
  assign bff_din  = {id_q, err_fin ? SLVERR : OKAY};
  assign bff_pop  = BVALID & BREADY;
  assign BVALID   = ~bff_empty;
  assign {bh_id, bh_resp} = bff_dout;
  assign BID      = BVALID ? bh_id : '0;
  assign BRESP    = BVALID ? bh_resp : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else if (start) begin
      state_q <= BURST;
      addr_q  <= a_addr;
      id_q    <= a_id;
      len_q   <= a_len;
      size_q  <= a_size;
      burst_q <= a_burst;
      beat_q  <= '0;
      err_q   <= start_err;
    end else if (last_hs) begin
      state_q <= IDLE;
    end else if (hs) begin
      beat_q  <= beat_q + 1'b1;
      addr_q  <= addr_nxt;
      err_q   <= err_fin;
    end
  end

endmodule

// File: tb/tb_asi_w.sv
// Directed bench for asi_w: burst addressing, error responses, B back-pressure and reset.
module tb_asi_w;
  import asi_pkg::*;

  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic [7:0]   AWID;
  logic [31:0]  AWADDR;
  logic [7:0]   AWLEN;
  logic [2:0]   AWSIZE;
  logic [1:0]   AWBURST;
  logic         AWVALID, AWREADY;
  logic [127:0] WDATA;
  logic [15:0]  WSTRB;
  logic         WLAST, WVALID, WREADY;
  logic [7:0]   BID;
  logic [1:0]   BRESP;
  logic         BVALID, BREADY;
  logic [7:0]   usr_wid;
  logic [31:0]  usr_waddr;
  logic [127:0] usr_wdata;
  logic [15:0]  usr_wstrb;
  logic         usr_wlast, usr_wvalid, usr_wready, usr_werr;

  int total = 0;
  int bad   = 0;
  bit stall = 1'b0;

  always #5 ACLK = ~ACLK;

  asi_w dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .usr_wid(usr_wid), .usr_waddr(usr_waddr), .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
    .usr_wlast(usr_wlast), .usr_wvalid(usr_wvalid), .usr_wready(usr_wready), .usr_werr(usr_werr)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the AW handshake.
  task automatic send_aw(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bt; AWVALID = 1'b1;
    @(negedge ACLK);
    while (!AWREADY && n < 40) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 40) chk("aw_timeout", 0, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] ea, input logic el,
                      input logic wl, input logic werr);
    int n = 0;
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    WVALID = 1'b1; WLAST = wl; WDATA = d; WSTRB = 16'hffff; usr_werr = werr;
    usr_wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge ACLK);
    while (!(usr_wvalid && WREADY) && n < 40) begin
      @(posedge ACLK); #1;
      usr_wready = (stall && n < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
      @(negedge ACLK);
    end
    if (n >= 40) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_addr"}, usr_waddr, ea);
      chk({tag, "_last"}, usr_wlast, el);
      chk({tag, "_data"}, usr_wdata, d);
    end
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0; usr_werr = 1'b0;
  endtask

  task automatic expect_b(input string tag, input logic [7:0] id, input logic [1:0] resp);
    int n = 0;
    @(negedge ACLK);
    while (!BVALID && n < 40) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 40) chk({tag, "_b_timeout"}, 0, 1);
    else begin
      chk({tag, "_bid"}, BID, id);
      chk({tag, "_bresp"}, BRESP, resp);
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    ARESETn = 1'b0; AWVALID = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0;
    AWBURST = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b1; usr_wready = 1'b1; usr_werr = 1'b0;

    // reset state
    repeat (2) @(negedge ACLK);
    chk("rst_awready", AWREADY, 1'b0);
    @(posedge ACLK); #1 ARESETn = 1'b1;
    WVALID = 1'b1;
    @(negedge ACLK);
    chk("rst_awready_hi", AWREADY, 1'b1);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_usr_wvalid", usr_wvalid, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_bid", BID, 8'h0);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_waddr", usr_waddr, 32'h0);
    chk("rst_wid", usr_wid, 8'h0);
    chk("rst_wlast", usr_wlast, 1'b0);
    @(posedge ACLK); #1 WVALID = 1'b0;

    // INCR
    send_aw(8'd5, 32'h1000, 8'd3, 3'd4, INCR);
    beat("incr0", 32'h1000, 1'b0, 1'b0, 1'b0);
    chk("incr_wid", usr_wid, 8'd5);
    beat("incr1", 32'h1010, 1'b0, 1'b0, 1'b0);
    beat("incr2", 32'h1020, 1'b0, 1'b0, 1'b0);
    beat("incr3", 32'h1030, 1'b1, 1'b1, 1'b0);
    expect_b("incr", 8'd5, OKAY);

    // WRAP across a 64-byte window
    send_aw(8'd6, 32'h1018, 8'd3, 3'd4, WRAP);
    beat("wrap0", 32'h1018, 1'b0, 1'b0, 1'b0);
    beat("wrap1", 32'h1028, 1'b0, 1'b0, 1'b0);
    beat("wrap2", 32'h1038, 1'b0, 1'b0, 1'b0);
    beat("wrap3", 32'h1008, 1'b1, 1'b1, 1'b0);
    expect_b("wrap", 8'd6, OKAY);

    // FIXED with early WLAST: still two beats, SLVERR
    send_aw(8'd7, 32'h40, 8'd1, 3'd2, FIXED);
    beat("fix0", 32'h40, 1'b0, 1'b1, 1'b0);
    @(negedge ACLK);
    chk("fix_no_b_early", BVALID, 1'b0);
    @(posedge ACLK); #1;
    beat("fix1", 32'h40, 1'b1, 1'b0, 1'b0);
    expect_b("fix", 8'd7, SLVERR);

    // B back-pressure: only four bursts may complete
    BREADY = 1'b0;
    for (int i = 1; i <= 5; i++) send_aw(8'(i), 32'(i * 32'h100), 8'd0, 3'd2, INCR);
    for (int i = 1; i <= 4; i++) beat("bp", 32'(i * 32'h100), 1'b1, 1'b1, 1'b0);
    WVALID = 1'b1; WLAST = 1'b1;
    repeat (6) @(negedge ACLK);
    chk("bp_wready_held", WREADY, 1'b0);
    chk("bp_usr_wvalid_held", usr_wvalid, 1'b0);
    chk("bp_bid_head", BID, 8'd1);
    @(posedge ACLK); #1 BREADY = 1'b1;
    @(posedge ACLK); #1 BREADY = 1'b0;
    beat("bp5", 32'h500, 1'b1, 1'b1, 1'b0);
    BREADY = 1'b1;
    for (int i = 2; i <= 5; i++) expect_b("bp", 8'(i), OKAY);
    @(negedge ACLK);
    chk("bp_drained", BVALID, 1'b0);
    @(posedge ACLK); #1;

    // user error on beat 2 with random usr_wready stalls
    stall = 1'b1;
    send_aw(8'd8, 32'h2000, 8'd7, 3'd4, INCR);
    for (int i = 0; i < 8; i++)
      beat("werr", 32'h2000 + 32'(i * 16), 1'(i == 7), 1'(i == 7), 1'(i == 2));
    stall = 1'b0;
    usr_wready = 1'b1;
    expect_b("werr", 8'd8, SLVERR);

    // reset in the middle of a burst, with a second AW queued
    send_aw(8'd9, 32'h3000, 8'd3, 3'd2, INCR);
    send_aw(8'd10, 32'h4000, 8'd0, 3'd2, INCR);
    beat("mid0", 32'h3000, 1'b0, 1'b0, 1'b0);
    WVALID = 1'b1;
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_awready", AWREADY, 1'b0);
    @(posedge ACLK); #1 ARESETn = 1'b1;
    repeat (4) @(negedge ACLK);
    chk("mid_bvalid", BVALID, 1'b0);
    chk("mid_aff_empty_wready", WREADY, 1'b0);
    chk("mid_usr_wvalid", usr_wvalid, 1'b0);
    @(posedge ACLK); #1 WVALID = 1'b0;
    send_aw(8'd11, 32'h5000, 8'd0, 3'd2, INCR);
    beat("fresh", 32'h5000, 1'b1, 1'b1, 1'b0);
    expect_b("fresh", 8'd11, OKAY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
